// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART family (uart_rx_os, uart_baud_tick, next-gen uart_tx).
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-clk tick every DIV clks, synchronous clear re-phases the count.
module uart_baud_tick #(
  parameter int unsigned DIV = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-of-3 vote per bit, configurable frame, one-word valid/ready buffer.
// Optional: define UART_RX_BREAK_DET_EN to swallow break frames and pulse brk_det instead.
module uart_rx_os #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 19200,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
`ifdef UART_RX_BREAK_DET_EN
  output logic                  brk_det,
`endif
  output logic                  rx_busy
);
  import uart_pkg::*;

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned OSW = $clog2(OVERSAMPLE) + 1;
  localparam int unsigned BW  = $clog2(DATA_WIDTH + 1);
  localparam logic [OSW-1:0] S_LO  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] S_MID = OSW'(OVERSAMPLE / 2);
  localparam logic [OSW-1:0] S_HI  = OSW'(OVERSAMPLE / 2 + 1);
  localparam logic [OSW-1:0] S_END = OSW'(OVERSAMPLE);

  logic [1:0]            sync_q;
  logic                  rx_s;
  rx_state_t             state_q, state_d;
  logic                  tick, clr;
  logic [OSW-1:0]        os_cnt_q, os_cnt_d, os_nxt;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [1:0]            samp_q, samp_d;
  logic                  par_flag_q, par_flag_d, frm_flag_q, frm_flag_d;
  logic                  commit_q, commit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic                  smp_lo, smp_mid, smp_hi, bit_end, vote, par_exp;
  logic                  last_stop, stop_done, brk_hit;
`ifdef UART_RX_BREAK_DET_EN
  logic                  par_bit_q, par_bit_d, brk_q, brk_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  // Divider held cleared while idle so tick 0 of the start bit lines up with the falling edge.
  assign clr = (state_q == IDLE);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (clr),
    .tick_o (tick)
  );

  // os_nxt is the tick index within the bit counted from the bit edge (edge itself is tick 0).
  assign os_nxt    = os_cnt_q + 1'b1;
  assign smp_lo    = tick && (os_nxt == S_LO);
  assign smp_mid   = tick && (os_nxt == S_MID);
  assign smp_hi    = tick && (os_nxt == S_HI);
  assign bit_end   = tick && (os_nxt == S_END);
  assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign par_exp   = (PARITY == PAR_ODD) ? ~(^shift_q) : ^shift_q;
  assign last_stop = (state_q == STOP) && (bit_cnt_q == BW'(STOP_BITS - 1));
  assign stop_done = last_stop && smp_hi;

`ifdef UART_RX_BREAK_DET_EN
  assign brk_hit = (shift_q == '0) && !par_bit_q && (frm_flag_q || !vote);
`else
  assign brk_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!rx_s) state_d = START;
      START: begin
        if (smp_hi && vote) state_d = IDLE;
        else if (bit_end)   state_d = DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt_q == BW'(DATA_WIDTH - 1)))
          state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
      end
      uart_pkg::PARITY: if (bit_end) state_d = STOP;
      STOP: begin
        if (stop_done) state_d = (rx_s && !brk_hit) ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_busy = (state_q != IDLE);
  end

  always_comb begin
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    par_flag_d = par_flag_q;
    frm_flag_d = frm_flag_q;
    commit_d   = stop_done && !brk_hit;
`ifdef UART_RX_BREAK_DET_EN
    par_bit_d  = par_bit_q;
    brk_d      = stop_done && brk_hit;
`endif
    if (state_q == IDLE) begin
      os_cnt_d   = '0;
      bit_cnt_d  = '0;
      par_flag_d = 1'b0;
      frm_flag_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit_d  = 1'b0;
`endif
    end else if (tick) begin
      os_cnt_d = bit_end ? '0 : os_nxt;
      if (smp_lo)  samp_d[0] = rx_s;
      if (smp_mid) samp_d[1] = rx_s;
      if (smp_hi) begin
        case (state_q)
          DATA: shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
          uart_pkg::PARITY: begin
            if (vote != par_exp) par_flag_d = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_d = vote;
`endif
          end
          STOP:    if (!vote) frm_flag_d = 1'b1;
          default: ;
        endcase
      end
      if (bit_end) begin
        if (state_q == DATA)
          bit_cnt_d = (bit_cnt_q == BW'(DATA_WIDTH - 1)) ? '0 : bit_cnt_q + 1'b1;
        else if (state_q == STOP)
          bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    // Frame flags are cleared in IDLE only at the end of the commit cycle, so they are still valid here.
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (commit_q) begin
      if (!valid_q || rx_ready) begin
        valid_d = 1'b1;
        data_d  = shift_q;
        perr_d  = par_flag_q;
        ferr_d  = frm_flag_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      samp_q     <= '0;
      par_flag_q <= 1'b0;
      frm_flag_q <= 1'b0;
      commit_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit_q  <= 1'b0;
      brk_q      <= 1'b0;
`endif
    end else begin
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      par_flag_q <= par_flag_d;
      frm_flag_q <= frm_flag_d;
      commit_q   <= commit_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_BREAK_DET_EN
      par_bit_q  <= par_bit_d;
      brk_q      <= brk_d;
`endif
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
`ifdef UART_RX_BREAK_DET_EN
  assign brk_det     = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: 8N1, 8E1 and 8N2 instances on a 160 clk/bit line.
module tb_uart_rx_os;

  localparam int unsigned CLKF     = 1600000;
  localparam int unsigned BAUD     = 10000;
  localparam int unsigned OS       = 16;
  localparam int unsigned BIT_CLKS = 160;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       rx1, rx2, rx3, rdy1, rdy2, rdy3;
  logic [7:0] data1, data2, data3;
  logic       valid1, valid2, valid3, perr1, perr2, perr3;
  logic       ferr1, ferr2, ferr3, ovr1, ovr2, ovr3, busy1, busy2, busy3;
`ifdef UART_RX_BREAK_DET_EN
  logic       brk1, brk2, brk3;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t q1[$], q2[$], q3[$];
  exp_t e1, e2, e3;
  int unsigned lat;

  uart_rx_os #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .DATA_WIDTH(8), .OVERSAMPLE(OS),
               .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .rx(rx1), .rx_data(data1), .rx_valid(valid1), .rx_ready(rdy1),
    .parity_err(perr1), .frame_err(ferr1), .overrun_err(ovr1),
`ifdef UART_RX_BREAK_DET_EN
    .brk_det(brk1),
`endif
    .rx_busy(busy1));

  uart_rx_os #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .DATA_WIDTH(8), .OVERSAMPLE(OS),
               .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .rx(rx2), .rx_data(data2), .rx_valid(valid2), .rx_ready(rdy2),
    .parity_err(perr2), .frame_err(ferr2), .overrun_err(ovr2),
`ifdef UART_RX_BREAK_DET_EN
    .brk_det(brk2),
`endif
    .rx_busy(busy2));

  uart_rx_os #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .DATA_WIDTH(8), .OVERSAMPLE(OS),
               .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .rx(rx3), .rx_data(data3), .rx_valid(valid3), .rx_ready(rdy3),
    .parity_err(perr3), .frame_err(ferr3), .overrun_err(ovr3),
`ifdef UART_RX_BREAK_DET_EN
    .brk_det(brk3),
`endif
    .rx_busy(busy3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int unsigned k, input logic v);
    case (k)
      1:       rx1 = v;
      2:       rx2 = v;
      default: rx3 = v;
    endcase
  endtask

  // frame[0] is the start bit; spike_bit/spike_off invert one clk of one bit (spike_bit < 0: none).
  task automatic send_frame(input int unsigned k, input logic [15:0] frame, input int unsigned nbits,
                            input int spike_bit, input int unsigned spike_off);
    for (int unsigned b = 0; b < nbits; b++) begin
      for (int unsigned i = 0; i < BIT_CLKS; i++) begin
        set_rx(k, (spike_bit == int'(b) && i == spike_off) ? ~frame[b] : frame[b]);
        step(1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst && valid1 && rdy1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL 8N1 unexpected word: got %0h want none", data1);
      end else begin
        e1 = q1.pop_front();
        chk("8N1 rx_data", 32'(data1), 32'(e1.d));
        chk("8N1 parity_err", 32'(perr1), 32'(e1.pe));
        chk("8N1 frame_err", 32'(ferr1), 32'(e1.fe));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && valid2 && rdy2) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL 8E1 unexpected word: got %0h want none", data2);
      end else begin
        e2 = q2.pop_front();
        chk("8E1 rx_data", 32'(data2), 32'(e2.d));
        chk("8E1 parity_err", 32'(perr2), 32'(e2.pe));
        chk("8E1 frame_err", 32'(ferr2), 32'(e2.fe));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && valid3 && rdy3) begin
      if (q3.size() == 0) begin
        total++; bad++;
        $display("FAIL 8N2 unexpected word: got %0h want none", data3);
      end else begin
        e3 = q3.pop_front();
        chk("8N2 rx_data", 32'(data3), 32'(e3.d));
        chk("8N2 parity_err", 32'(perr3), 32'(e3.pe));
        chk("8N2 frame_err", 32'(ferr3), 32'(e3.fe));
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    rx1 = 1'b1; rx2 = 1'b1; rx3 = 1'b1;
    rdy1 = 1'b1; rdy2 = 1'b1; rdy3 = 1'b1;
    step(3);
    chk("reset rx_valid", 32'(valid1), 0);
    chk("reset rx_data", 32'(data1), 0);
    chk("reset flags", 32'({perr1, ferr1, ovr1}), 0);
    chk("reset rx_busy", 32'(busy1), 0);
    chk("reset others valid", 32'({valid2, valid3}), 0);
    rst = 1'b1;
    step(5);

    // 8N1 0xA5: latency from the start edge and a one-clk valid pulse with ready held high
    q1.push_back({8'hA5, 1'b0, 1'b0});
    fork
      send_frame(1, {6'h3F, 1'b1, 8'hA5, 1'b0}, 10, -1, 0);
      begin
        lat = 0;
        while (!valid1 && lat < 2000) begin
          step(1);
          lat++;
        end
        chk("8N1 latency window", 32'(lat >= 1490 && lat <= 1560), 1);
        step(1);
        chk("8N1 valid one clk", 32'(valid1), 0);
      end
    join
    rx1 = 1'b1;
    step(BIT_CLKS);

    // 8E1 0x3C: correct even parity 0, then wrong parity 1
    q2.push_back({8'h3C, 1'b0, 1'b0});
    send_frame(2, {5'h1F, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, -1, 0);
    rx2 = 1'b1;
    step(BIT_CLKS);
    q2.push_back({8'h3C, 1'b1, 1'b0});
    send_frame(2, {5'h1F, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, -1, 0);
    rx2 = 1'b1;
    step(BIT_CLKS);

    // 8N2 0x5A with second stop bit 0 and the line left low afterwards
    q3.push_back({8'h5A, 1'b0, 1'b1});
    send_frame(3, {5'h00, 1'b0, 1'b1, 8'h5A, 1'b0}, 11, -1, 0);
    step(2 * BIT_CLKS);
    chk("8N2 word delivered", 32'(q3.size()), 0);
    chk("8N2 holds in WAIT_HIGH", 32'(busy3), 1);
    rx3 = 1'b1;
    step(5);
    chk("8N2 idle after line high", 32'(busy3), 0);

    // start glitch: 5 clk low
    rx1 = 1'b0;
    step(5);
    chk("glitch start seen", 32'(busy1), 1);
    rx1 = 1'b1;
    step(200);
    chk("glitch busy back to 0", 32'(busy1), 0);
    chk("glitch no valid", 32'(valid1), 0);
    chk("glitch no flags", 32'({perr1, ferr1, ovr1}), 0);

    // 0xF0 with a one-clk inverted spike on the middle sample of data bit 5
    q1.push_back({8'hF0, 1'b0, 1'b0});
    send_frame(1, {6'h3F, 1'b1, 8'hF0, 1'b0}, 10, 6, 80);
    rx1 = 1'b1;
    step(BIT_CLKS);

    // overrun: ready low, two frames, only the first is held
    rdy1 = 1'b0;
    q1.push_back({8'h11, 1'b0, 1'b0});
    send_frame(1, {6'h3F, 1'b1, 8'h11, 1'b0}, 10, -1, 0);
    rx1 = 1'b1;
    step(BIT_CLKS);
    send_frame(1, {6'h3F, 1'b1, 8'h22, 1'b0}, 10, -1, 0);
    rx1 = 1'b1;
    step(BIT_CLKS);
    chk("overrun held data", 32'(data1), 32'h11);
    chk("overrun valid held", 32'(valid1), 1);
    chk("overrun flag", 32'(ovr1), 1);
    rdy1 = 1'b1;
    step(1);
    chk("overrun valid clears", 32'(valid1), 0);
    chk("overrun flag sticky", 32'(ovr1), 1);

    // reset in the middle of a frame
    send_frame(1, {6'h3F, 1'b1, 8'h77, 1'b0}, 4, -1, 0);
    chk("mid-frame busy", 32'(busy1), 1);
    rst = 1'b0;
    rx1 = 1'b1;
    step(2);
    chk("mid-frame reset valid", 32'(valid1), 0);
    chk("mid-frame reset data", 32'(data1), 0);
    chk("mid-frame reset flags", 32'({perr1, ferr1, ovr1}), 0);
    chk("mid-frame reset busy", 32'(busy1), 0);
    rst = 1'b1;
    step(2000);
    chk("after reset no valid", 32'(valid1), 0);
    chk("after reset idle", 32'(busy1), 0);

    chk("8N1 queue drained", 32'(q1.size()), 0);
    chk("8E1 queue drained", 32'(q2.size()), 0);
    chk("8N2 queue drained", 32'(q3.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver. It succeeds the fixed 8N1 receiver and sits beside uart_tx on the serial line.
- Adds programmable data width, parity and stop-bit count.
- Samples each bit 3 times and takes a majority vote.
- Reports parity, framing and overrun errors.
- Holds each received word in a one-entry buffer with a valid/ready handshake toward the consumer.

Parameters:
- CLK_FREQ, 50000000: system clock in Hz.
- BAUD_RATE, 19200: line rate in bit/s.
- DATA_WIDTH, 8: data bits per frame. Legal range 5..9.
- OVERSAMPLE, 16: sample ticks per bit. Must be an even number ≥ 8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low; takes effect on the clk edge while low.
- rx  in  1  asynchronous serial input; idle high.
- rx_data  out  DATA_WIDTH  received word, LSB = first bit on the line.
- rx_valid  out  1  rx_data and the error flags are valid.
- rx_ready  in  1  consumer accepts the word.
- parity_err  out  1  parity mismatch on the held word.
- frame_err  out  1  a stop bit sampled 0 on the held word.
- overrun_err  out  1  sticky: a frame was lost because the buffer was full.
- rx_busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst low at a clk edge): all outputs 0, FSM to IDLE, counters 0, synchronizer flops set to 1.
- Input synchronizer: rx passes through 2 flops before use.
- Tick divider:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division. DIV = 162 at the defaults.
  - Tick pulses 1 clk every DIV clks.
  - Divider is cleared when a start is detected, so sampling is phase-aligned to the falling edge.
- Majority vote: samples taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit; the bit value is the 2-of-3 vote.
- FSM transitions:
  - IDLE: synchronized rx = 0 → START.
  - START: vote = 1 → IDLE (glitch rejected, nothing reported). Vote = 0 → DATA.
  - DATA: DATA_WIDTH bits, LSB first, shifted into a shift register; each bit lasts OVERSAMPLE ticks. Last bit done → PARITY if PARITY ≠ 0, else STOP.
  - PARITY: compute the expected bit (odd parity: XOR of data is inverted). Mismatch sets the pending parity flag.
  - STOP: STOP_BITS bits. Any stop bit voting 0 sets the pending frame flag.
  - After the vote of the last stop bit: commit, then → IDLE if synchronized rx = 1, else → WAIT_HIGH.
  - WAIT_HIGH: stay until synchronized rx = 1, then → IDLE. This prevents retriggering on a line held low.
- Commit (1 clk after the last stop vote):
  - If rx_valid = 0: load rx_data, parity_err and frame_err; set rx_valid.
  - If rx_valid = 1 and rx_ready = 0 in that cycle: discard the frame, set overrun_err, keep the held word unchanged.
  - If rx_valid = 1 and rx_ready = 1 in the same cycle: the old word is consumed and the new word loads. No overrun.
- Handshake:
  - rx_valid stays high until a clk where rx_ready = 1.
  - On that clk rx_valid clears, unless a commit loads a new word in the same cycle.
  - rx_data is stable while rx_valid = 1.
  - overrun_err clears only on reset.
- Latency: rx_valid rises 1 clk after the middle sample of the last stop bit, i.e. ~(1+DATA_WIDTH+P+STOP_BITS-0.5) bit times after the falling edge of the start bit, where P = 1 if PARITY ≠ 0, else 0.
- Reset mid-frame: the frame is abandoned with no valid and no flags.
- Line stuck low at power-up: one start is detected, the frame completes with frame_err = 1, then the FSM holds in WAIT_HIGH.

Optional Feature:
UART_RX_BREAK_DET_EN.
- Defined:
  - Adds output brk_det (1 bit, resets to 0).
  - When a committed frame has all data bits 0, parity (if any) 0 and frame_err = 1, that word is not delivered (rx_valid stays low).
  - Instead brk_det pulses high for 1 clk and the FSM enters WAIT_HIGH.
- Undefined: no brk_det port; a break is reported as a normal word 0x00 with frame_err = 1.

Decomposition:
- Package uart_pkg holds:
  - typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH};
  - parity-mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - function calc_div(clk_freq, baud, os).
- Sub-module uart_baud_tick: DIV counter with synchronous clear input and a tick output. It is reusable by the next-generation uart_tx.

Test Plan:
All scenarios use CLK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16, giving DIV = 10 and 160 clk/bit.
- 8N1, send 0xA5 with rx_ready held 1 → rx_valid pulses 1 clk with rx_data=0xA5, parity_err=0, frame_err=0, ~1520 clk after the start edge.
- 8E1 (PARITY=2), send 0x3C with correct parity 0, then 0x3C with parity 1 → first word has parity_err=0, second has parity_err=1. rx_data=0x3C both times.
- 8N2, send 0x5A with the second stop bit forced 0 → rx_data=0x5A, frame_err=1, FSM waits in WAIT_HIGH until rx returns high.
- Start glitch: rx low for 5 clk then high → no rx_valid, rx_busy returns to 0, no flags.
- Overrun: rx_ready held 0, send 0x11 then 0x22 → rx_data stays 0x11, overrun_err=1. Assert rx_ready → rx_valid clears next clk.
- Noise and reset: single-clk inverted spike at a sample point of a data bit of 0xF0 → still received as 0xF0. Pull rst low mid-frame → no rx_valid and all outputs 0.
